// File: rtl/chip8_decode_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chip8_decode_pipe : byte-stream CHIP-8/SUPER-CHIP decoder with out FIFO  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module chip8_decode_pipe #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [11:0] RESET_PC   = 12'h200,
  parameter bit          SUPER_CHIP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        pc_load,
  input  logic [11:0] pc_in,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [5:0]  op,
  output logic [11:0] op_pc,
  output logic [11:0] addr_out,
  output logic [3:0]  x,
  output logic [3:0]  y,
  output logic [3:0]  nib,
  output logic [7:0]  val,
  output logic        illegal
);

  localparam int              c_ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_ADDR_W:0] c_DEPTH = (c_ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_HI = 1'b0, ST_LO = 1'b1} state_t;

  state_t              r_state;
  logic [7:0]          r_hi;
  logic [11:0]         r_pc;
  logic [c_ADDR_W-1:0] r_wptr;
  logic [c_ADDR_W-1:0] r_rptr;
  logic [c_ADDR_W:0]   r_count;
  logic [5:0]          r_op_mem  [FIFO_DEPTH];
  logic [11:0]         r_pc_mem  [FIFO_DEPTH];
  logic [15:0]         r_ins_mem [FIFO_DEPTH];

  logic [15:0] w_instr;
  logic [5:0]  w_op;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [15:0] w_head_ins;
  logic [5:0]  w_head_op;

  assign w_instr    = {r_hi, byte_in};
  assign op_valid   = (r_count != '0);
  assign byte_ready = (r_state == ST_HI) || (r_count < c_DEPTH);
  assign w_accept   = byte_valid && byte_ready && !pc_load;
  assign w_push     = w_accept && (r_state == ST_LO);
  assign w_pop      = op_valid && op_ready && !pc_load;

  always_comb begin
    w_op = 6'd0;
    case (w_instr[15:12])
      4'h0: begin
        if (w_instr[11:0] == 12'h0E0)      w_op = 6'd1;
        else if (w_instr[11:0] == 12'h0EE) w_op = 6'd2;
        else if (SUPER_CHIP) begin
          if (w_instr[11:4] == 8'h0C) w_op = 6'd36;
          else begin
            case (w_instr[11:0])
              12'h0FB: w_op = 6'd37;
              12'h0FC: w_op = 6'd38;
              12'h0FD: w_op = 6'd39;
              12'h0FE: w_op = 6'd40;
              12'h0FF: w_op = 6'd41;
              default: w_op = 6'd0;
            endcase
          end
        end
      end
      4'h1: w_op = 6'd3;
      4'h2: w_op = 6'd4;
      4'h3: w_op = 6'd5;
      4'h4: w_op = 6'd6;
      4'h5: if (w_instr[3:0] == 4'h0) w_op = 6'd7;
      4'h6: w_op = 6'd8;
      4'h7: w_op = 6'd9;
      4'h8: begin
        if (w_instr[3] == 1'b0)         w_op = 6'd10 + {3'b000, w_instr[2:0]};
        else if (w_instr[3:0] == 4'hE) w_op = 6'd18;
      end
      4'h9: if (w_instr[3:0] == 4'h0) w_op = 6'd19;
      4'hA: w_op = 6'd20;
      4'hB: w_op = 6'd21;
      4'hC: w_op = 6'd22;
      4'hD: w_op = 6'd23;
      4'hE: begin
        if (w_instr[7:0] == 8'h9E)      w_op = 6'd24;
        else if (w_instr[7:0] == 8'hA1) w_op = 6'd25;
      end
      default: begin
        case (w_instr[7:0])
          8'h07: w_op = 6'd26;
          8'h0A: w_op = 6'd27;
          8'h15: w_op = 6'd28;
          8'h18: w_op = 6'd29;
          8'h1E: w_op = 6'd30;
          8'h29: w_op = 6'd32;
          8'h33: w_op = 6'd33;
          8'h55: w_op = 6'd34;
          8'h65: w_op = 6'd35;
          8'h30: w_op = SUPER_CHIP ? 6'd42 : 6'd0;
          8'h75: w_op = SUPER_CHIP ? 6'd43 : 6'd0;
          8'h85: w_op = SUPER_CHIP ? 6'd44 : 6'd0;
          default: w_op = 6'd0;
        endcase
      end
    endcase
  end

  // Flush wins over everything: pointers collapse, pending high byte is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_HI;
      r_hi    <= 8'h00;
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (pc_load) begin
      r_state <= ST_HI;
      r_pc    <= pc_in;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        if (r_state == ST_HI) begin
          r_hi    <= byte_in;
          r_state <= ST_LO;
        end else begin
          r_state <= ST_HI;
          r_pc    <= r_pc + 12'd2;
        end
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wptr]  <= w_op;
      r_pc_mem[r_wptr]  <= r_pc;
      r_ins_mem[r_wptr] <= w_instr;
    end
  end

  // Head outputs read as zero whenever the FIFO is empty.
  assign w_head_ins = op_valid ? r_ins_mem[r_rptr] : 16'h0000;
  assign w_head_op  = op_valid ? r_op_mem[r_rptr]  : 6'd0;
  assign op         = w_head_op;
  assign op_pc      = op_valid ? r_pc_mem[r_rptr] : 12'h000;
  assign addr_out   = w_head_ins[11:0];
  assign x          = w_head_ins[11:8];
  assign y          = w_head_ins[7:4];
  assign nib        = w_head_ins[3:0];
  assign val        = w_head_ins[7:0];
  assign illegal    = op_valid && (w_head_op == 6'd0);

endmodule
`default_nettype wire

// File: tb/tb_chip8_decode_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_chip8_decode_pipe : scoreboard bench, CHIP-8 and SUPER-CHIP instances |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_chip8_decode_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        pc_load = 1'b0;
  logic [11:0] pc_in = 12'h000;
  logic        op_ready = 1'b0;

  logic        byte_ready0, op_valid0, illegal0;
  logic [5:0]  op0;
  logic [11:0] op_pc0, addr0;
  logic [3:0]  x0, y0, nib0;
  logic [7:0]  val0;
  logic        byte_ready1, op_valid1, illegal1;
  logic [5:0]  op1;
  logic [11:0] op_pc1, addr1;
  logic [3:0]  x1, y1, nib1;
  logic [7:0]  val1;

  typedef struct packed {
    logic [15:0] ins;
    logic [11:0] pc;
    logic [5:0]  op_c8;
    logic [5:0]  op_sc;
  } sb_t;

  sb_t         sb[$];
  sb_t         r_head;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] exp_pc = 12'h200;

  always #5 clk = ~clk;

  chip8_decode_pipe #(.FIFO_DEPTH(4), .RESET_PC(12'h200), .SUPER_CHIP(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready0),
    .pc_load(pc_load), .pc_in(pc_in), .op_valid(op_valid0), .op_ready(op_ready),
    .op(op0), .op_pc(op_pc0), .addr_out(addr0), .x(x0), .y(y0), .nib(nib0), .val(val0),
    .illegal(illegal0)
  );

  chip8_decode_pipe #(.FIFO_DEPTH(4), .RESET_PC(12'h200), .SUPER_CHIP(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready1),
    .pc_load(pc_load), .pc_in(pc_in), .op_valid(op_valid1), .op_ready(op_ready),
    .op(op1), .op_pc(op_pc1), .addr_out(addr1), .x(x1), .y(y1), .nib(nib1), .val(val1),
    .illegal(illegal1)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every pop seen by the consumer is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rst && op_valid0 && op_ready && !pc_load) begin
      check_eq("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        r_head = sb.pop_front();
        check_eq("op_pc",      op_pc0,   r_head.pc);
        check_eq("op_c8",      op0,      r_head.op_c8);
        check_eq("illegal_c8", illegal0, r_head.op_c8 == 6'd0);
        check_eq("fields_c8", {addr0, x0, y0, nib0, val0},
                 {r_head.ins[11:0], r_head.ins[11:8], r_head.ins[7:4], r_head.ins[3:0], r_head.ins[7:0]});
        check_eq("valid_sc",   op_valid1, 1'b1);
        check_eq("op_pc_sc",   op_pc1,   r_head.pc);
        check_eq("op_sc",      op1,      r_head.op_sc);
        check_eq("illegal_sc", illegal1, r_head.op_sc == 6'd0);
        check_eq("fields_sc", {addr1, x1, y1, nib1, val1},
                 {r_head.ins[11:0], r_head.ins[11:8], r_head.ins[7:4], r_head.ins[3:0], r_head.ins[7:0]});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = byte_ready0;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    check_eq("byte_accept", 64'(ok), 64'd1);
  endtask

  task automatic push_exp(input logic [15:0] ins, input logic [5:0] oc8, input logic [5:0] osc);
    sb_t e;
    e.ins   = ins;
    e.pc    = exp_pc;
    e.op_c8 = oc8;
    e.op_sc = osc;
    sb.push_back(e);
    exp_pc = exp_pc + 12'd2;
  endtask

  task automatic send_word(input logic [15:0] ins, input logic [5:0] oc8, input logic [5:0] osc);
    send_byte(ins[15:8]);
    send_byte(ins[7:0]);
    push_exp(ins, oc8, osc);
  endtask

  task automatic drain();
    op_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_eq("drained", 64'(sb.size()), 64'd0);
    check_eq("empty_valid", op_valid0, 1'b0);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    byte_valid = 1'b0;
    pc_load    = 1'b0;
    op_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid",   op_valid0,   1'b0);
    check_eq("rst_ready",   byte_ready0, 1'b1);
    check_eq("rst_op",      op0,         6'd0);
    check_eq("rst_op_pc",   op_pc0,      12'h000);
    check_eq("rst_illegal", illegal0,    1'b0);
    sb.delete();
    exp_pc = 12'h200;
    rst    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Latency: entry visible right after the low-byte edge.
    do_reset();
    op_ready = 1'b1;
    send_byte(8'h00);
    check_eq("lat_pre", op_valid0, 1'b0);
    send_byte(8'hE0);
    push_exp(16'h00E0, 6'd1, 6'd1);
    check_eq("lat_post", op_valid0, 1'b1);
    drain();

    do_reset();
    op_ready = 1'b1;
    send_word(16'hD125, 6'd23, 6'd23);
    send_word(16'h8AB0, 6'd10, 6'd10);
    send_word(16'hC37F, 6'd22, 6'd22);
    drain();

    // Back-pressure: fifth word stalls in LO until one pop frees a slot.
    do_reset();
    send_word(16'h1234, 6'd3, 6'd3);
    send_word(16'h2456, 6'd4, 6'd4);
    send_word(16'h3A12, 6'd5, 6'd5);
    send_word(16'h4B34, 6'd6, 6'd6);
    send_byte(8'h6C);
    byte_in    = 8'h56;
    byte_valid = 1'b1;
    @(negedge clk);
    check_eq("full_ready",  byte_ready0, 1'b0);
    check_eq("full_valid",  op_valid0,   1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("full_ready2", byte_ready0, 1'b0);
    @(posedge clk);
    #1;
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    op_ready = 1'b0;
    send_byte(8'h56);
    push_exp(16'h6C56, 6'd8, 6'd8);
    drain();

    // Flush with pop request and byte offered in the same cycle.
    do_reset();
    send_word(16'h1111, 6'd3, 6'd3);
    send_word(16'h2222, 6'd4, 6'd4);
    send_byte(8'h33);
    pc_load    = 1'b1;
    pc_in      = 12'h300;
    op_ready   = 1'b1;
    byte_in    = 8'h44;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    pc_load    = 1'b0;
    byte_valid = 1'b0;
    sb.delete();
    exp_pc = 12'h300;
    check_eq("flush_valid", op_valid0, 1'b0);
    send_word(16'h6055, 6'd8, 6'd8);
    drain();

    do_reset();
    op_ready = 1'b1;
    send_word(16'h00FF, 6'd0,  6'd41);
    send_word(16'h5121, 6'd0,  6'd0);
    send_word(16'h00C3, 6'd0,  6'd36);
    send_word(16'h00FB, 6'd0,  6'd37);
    send_word(16'hF030, 6'd0,  6'd42);
    send_word(16'hD120, 6'd23, 6'd23);
    send_word(16'h8AB8, 6'd0,  6'd0);
    send_word(16'hE19E, 6'd24, 6'd24);
    send_word(16'hF165, 6'd35, 6'd35);
    send_word(16'h0123, 6'd0,  6'd0);
    send_word(16'hF129, 6'd32, 6'd32);
    send_word(16'h8ABE, 6'd18, 6'd18);
    send_word(16'h9120, 6'd19, 6'd19);
    drain();

    // PC wrap at the top of the 4 KiB space.
    pc_load = 1'b1;
    pc_in   = 12'hFFE;
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    exp_pc  = 12'hFFE;
    send_word(16'hA123, 6'd20, 6'd20);
    send_word(16'hB456, 6'd21, 6'd21);
    drain();

    // Asynchronous reset while a high byte is pending.
    op_ready = 1'b0;
    send_word(16'h7A01, 6'd9, 6'd9);
    send_byte(8'h12);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_valid", op_valid0,   1'b0);
    check_eq("arst_ready", byte_ready0, 1'b1);
    check_eq("arst_op_pc", op_pc0,      12'h000);
    sb.delete();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    exp_pc   = 12'h200;
    op_ready = 1'b1;
    send_word(16'h3A12, 6'd5, 6'd5);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
